ks_data_path_param: RTL



---
 rtl/k_and_s_pkg.sv | 42 ++++
 rtl/ks_data_path_param_if.sv | 40 ++++
 rtl/ks_data_path_param_reg_file.sv | 46 ++++
 rtl/ks_data_path_param.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared K&S definitions: decoded instruction type, opcode encodings and
// ALU operation codes used by the datapath and control unit.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BNNEG,
        I_BNZERO,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_HALT
    } decoded_instruction_type;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BNNEG  = 8'h0A;
    localparam logic [7:0] OP_BNZERO = 8'h0B;
    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    localparam logic [1:0] ALU_OR  = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

endpackage

// File: rtl/ks_data_path_param_if.sv
// Control-unit / memory bus of the K&S datapath. master = control unit and
// memory side, slave = datapath.
interface ks_data_path_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    import k_and_s_pkg::*;

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       data_out;
    logic [DATA_W-1:0]       data_in;

    modport master (
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, data_in,
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out
    );

    modport slave (
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, data_in,
        output decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out
    );

endinterface

// File: rtl/ks_data_path_param_reg_file.sv
// K&S register file: two asynchronous read ports, one synchronous write port.
// With KS_DP_ZERO_REG_EN defined, register 0 is hardwired to zero.
module ks_reg_file #(
    parameter int  DATA_W = 16,
    parameter int  NREGS  = 4,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] a_addr,
    input  logic [REG_AW-1:0] b_addr,
    input  logic [REG_AW-1:0] c_addr,
    input  logic              we,
    input  logic [DATA_W-1:0] c_data,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[c_addr] = c_data;
        end
`ifdef KS_DP_ZERO_REG_EN
        // Entry 0 never leaves its reset value, so plain reads return 0.
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign a_data = regs_q[a_addr];
    assign b_data = regs_q[b_addr];

endmodule

// File: rtl/ks_data_path_param.sv
// Parametrised K&S datapath: IR, decoder, register file, ALU, flags, PC and
// RAM address mux. Optional KS_DP_ZERO_REG_EN hardwires register 0 to zero.
module ks_data_path_param
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ks_data_path_param_if.slave  bus
);

    localparam int REG_AW = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [DATA_W-1:0]       ir_q, ir_d;
    logic [ADDR_W-1:0]       pc_q, pc_d;
    logic                    zero_q, zero_d;
    logic                    neg_q, neg_d;
    logic                    uovf_q, uovf_d;
    logic                    sovf_q, sovf_d;

    logic [7:0]              opcode;
    logic [ADDR_W-1:0]       addr_field;
    logic [REG_AW-1:0]       a_addr, b_addr, c_addr;
    decoded_instruction_type dec;

    logic [DATA_W-1:0]       a_data, b_data, c_data;
    logic [DATA_W-1:0]       alu_res;
    logic [DATA_W:0]         alu_wide;
    logic                    alu_zero, alu_neg, alu_uovf, alu_sovf;
    logic                    unused_ir;

    // Decoder: every register index not used by the opcode stays 0.
    always_comb begin
        opcode     = ir_q[DATA_W-1 -: 8];
        addr_field = ir_q[ADDR_W-1:0];
        dec        = I_NOP;
        a_addr     = '0;
        b_addr     = '0;
        c_addr     = '0;
        case (opcode)
            OP_BRANCH: dec = I_BRANCH;
            OP_BZERO:  dec = I_BZERO;
            OP_BNEG:   dec = I_BNEG;
            OP_BNNEG:  dec = I_BNNEG;
            OP_BNZERO: dec = I_BNZERO;
            OP_HALT:   dec = I_HALT;
            OP_LOAD: begin
                dec    = I_LOAD;
                c_addr = ir_q[ADDR_W+REG_AW-1:ADDR_W];
            end
            OP_STORE: begin
                dec    = I_STORE;
                a_addr = ir_q[ADDR_W+REG_AW-1:ADDR_W];
            end
            OP_MOVE: begin
                dec    = I_MOVE;
                a_addr = ir_q[REG_AW-1:0];
                b_addr = ir_q[REG_AW-1:0];
                c_addr = ir_q[2*REG_AW-1:REG_AW];
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                case (opcode)
                    OP_ADD:  dec = I_ADD;
                    OP_SUB:  dec = I_SUB;
                    OP_AND:  dec = I_AND;
                    default: dec = I_OR;
                endcase
                a_addr = ir_q[REG_AW-1:0];
                b_addr = ir_q[2*REG_AW-1:REG_AW];
                c_addr = ir_q[3*REG_AW-1:2*REG_AW];
            end
            default: dec = I_NOP;
        endcase
    end

    ks_reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .c_addr (c_addr),
        .we     (bus.write_reg_enable),
        .c_data (c_data),
        .a_data (a_data),
        .b_data (b_data)
    );

    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_uovf = 1'b0;
        alu_sovf = 1'b0;
        case (bus.operation)
            ALU_ADD: begin
                alu_wide = {1'b0, a_data} + {1'b0, b_data};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_uovf = alu_wide[DATA_W];
                alu_sovf = (a_data[DATA_W-1] == b_data[DATA_W-1]) &&
                           (alu_res[DATA_W-1] != a_data[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res  = a_data - b_data;
                alu_uovf = (a_data < b_data);
                alu_sovf = (a_data[DATA_W-1] != b_data[DATA_W-1]) &&
                           (alu_res[DATA_W-1] != a_data[DATA_W-1]);
            end
            ALU_AND: alu_res = a_data & b_data;
            default: alu_res = a_data | b_data;
        endcase
        alu_zero = (alu_res == '0);
        alu_neg  = alu_res[DATA_W-1];
    end

    assign c_data = bus.c_sel ? bus.data_in : alu_res;

    always_comb begin
        ir_d   = bus.ir_enable ? bus.data_in : ir_q;
        pc_d   = pc_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        uovf_d = uovf_q;
        sovf_d = sovf_q;
        if (bus.pc_enable) begin
            pc_d = bus.branch ? addr_field : pc_q + PC_ONE;
        end
        if (bus.flags_reg_enable) begin
            zero_d = alu_zero;
            neg_d  = alu_neg;
            uovf_d = alu_uovf;
            sovf_d = alu_sovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= '0;
            pc_q   <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uovf_q <= 1'b0;
            sovf_q <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            pc_q   <= pc_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            uovf_q <= uovf_d;
            sovf_q <= sovf_d;
        end
    end

    // Not every IR bit is an operand field for every width choice.
    assign unused_ir = ^ir_q;

    assign bus.decoded_instruction = dec;
    assign bus.zero_op             = zero_q;
    assign bus.neg_op              = neg_q;
    assign bus.unsigned_overflow   = uovf_q;
    assign bus.signed_overflow     = sovf_q;
    assign bus.ram_addr            = bus.addr_sel ? pc_q : addr_field;
    assign bus.data_out            = a_data;

endmodule
